// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - serial boot loader that writes framed words into instruction memory.
// Frame: SYNC, N[15:8], N[7:0], 4*N big-endian payload bytes, mod-256 payload checksum.
module imem_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_WORDS      = 256,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count
);

  localparam int          TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR
  } state_t;

  state_t        state_q;
  logic [15:0]   len_q;
  logic [15:0]   word_idx_q;
  logic [1:0]    byte_idx_q;
  logic [23:0]   shift_q;
  logic [7:0]    csum_q;
  logic [TW-1:0] idle_q;
  logic          imem_we_q;
  logic [31:0]   imem_addr_q;
  logic [31:0]   imem_wdata_q;
  logic          cpu_hold_q;
  logic          done_q;
  logic          err_q;
  logic [15:0]   word_count_q;

  logic [15:0] len_w;
  logic        in_frame;

  assign len_w    = {len_q[15:8], rx_data};
  assign in_frame = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                    (state_q == DATA)   || (state_q == CHECK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      csum_q       <= '0;
      idle_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      imem_we_q <= 1'b0;

      // Idle watchdog only acts on cycles without a byte, so it never races the byte handling below.
      if (in_frame) begin
        if (rx_valid) begin
          idle_q <= '0;
        end else if (idle_q == TO_LAST) begin
          idle_q     <= '0;
          state_q    <= ERROR;
          err_q      <= 1'b1;
          done_q     <= 1'b0;
          cpu_hold_q <= 1'b1;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end

      case (state_q)
        IDLE, DONE, ERROR: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_q      <= LEN_HI;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
            cpu_hold_q   <= 1'b1;
            csum_q       <= '0;
            idle_q       <= '0;
          end
        end
        LEN_HI: begin
          if (rx_valid) begin
            len_q[15:8] <= rx_data;
            state_q     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (rx_valid) begin
            len_q      <= len_w;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            if (len_w == 16'd0 || {1'b0, len_w} > MAX_W) begin
              state_q    <= ERROR;
              err_q      <= 1'b1;
              cpu_hold_q <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (rx_valid) begin
            csum_q <= csum_q + rx_data;
            if (byte_idx_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= {16'd0, word_idx_q};
              imem_wdata_q <= {shift_q, rx_data};
              word_count_q <= word_idx_q + 16'd1;
              word_idx_q   <= word_idx_q + 16'd1;
              byte_idx_q   <= 2'd0;
              if (word_idx_q == len_q - 16'd1) state_q <= CHECK;
            end else begin
              shift_q    <= {shift_q[15:0], rx_data};
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
        end
        CHECK: begin
          if (rx_valid) begin
            if (rx_data == csum_q) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q    <= ERROR;
              err_q      <= 1'b1;
              cpu_hold_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized frame loader bench with a frame-level reference model.
module tb_imem_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int MAXW = 256;
  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] wq[$];

  imem_loader #(.SYNC_BYTE(SYNC), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we) begin
      wq.push_back({imem_addr, imem_wdata});
      check_val("wc_at_we", 64'(word_count), 64'(imem_addr + 32'd1));
    end
    if (done && err) check_val("done_err_excl", 64'(1), 64'(0));
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_outputs(input int exp_n, input logic [31:0] w[$], input logic exp_done,
                               input int exp_wc);
    check_val("nwr", 64'(wq.size()), 64'(exp_n));
    for (int i = 0; i < exp_n && i < wq.size(); i++)
      check_val("wr", wq[i], {32'(i), w[i]});
    check_val("done", 64'(done), 64'(exp_done));
    check_val("err", 64'(err), 64'(!exp_done));
    check_val("cpu_hold", 64'(cpu_hold), 64'(!exp_done));
    check_val("word_count", 64'(word_count), 64'(exp_wc));
  endtask

  // Reference: a frame is good iff 1<=N<=MAXW; all N words land at addr 0..N-1;
  // done iff the trailing byte equals the mod-256 payload sum.
  task automatic load_frame(input int n, input logic [31:0] w[$], input int cs_adj, input int maxgap);
    logic [7:0]  bq[$];
    logic [15:0] n16;
    logic [31:0] wv;
    int          sum;
    logic        valid;
    n16   = 16'(n);
    sum   = 0;
    valid = (n >= 1) && (n <= MAXW);
    bq.push_back(SYNC);
    bq.push_back(n16[15:8]);
    bq.push_back(n16[7:0]);
    if (valid) begin
      for (int i = 0; i < n; i++) begin
        wv = w[i];
        for (int b = 3; b >= 0; b--) begin
          bq.push_back(wv[8*b +: 8]);
          sum += int'(wv[8*b +: 8]);
        end
      end
      bq.push_back(8'((sum + cs_adj) % 256));
    end
    wq.delete();
    foreach (bq[i]) begin
      idle($urandom_range(0, maxgap));
      put(bq[i]);
    end
    idle(3);
    check_outputs(valid ? n : 0, w, valid && (cs_adj % 256 == 0), valid ? n : 0);
  endtask

  task automatic rand_words(input int n, output logic [31:0] w[$]);
    w.delete();
    for (int i = 0; i < n; i++) w.push_back($urandom());
  endtask

  initial begin
    logic [31:0] w[$];
    logic [7:0]  junk;
    int          n;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(2);
    check_val("rst_we", 64'(imem_we), 64'(0));
    check_val("rst_addr", 64'(imem_addr), 64'(0));
    check_val("rst_wdata", 64'(imem_wdata), 64'(0));
    check_val("rst_hold", 64'(cpu_hold), 64'(0));
    check_val("rst_done", 64'(done), 64'(0));
    check_val("rst_err", 64'(err), 64'(0));
    check_val("rst_wc", 64'(word_count), 64'(0));
    reset = 1'b0;
    idle(1);

    w = '{32'h20080005, 32'h20090007};
    load_frame(2, w, 0, 2);
    load_frame(2, w, 1, 2);

    w.delete();
    load_frame(0, w, 0, 1);
    load_frame(257, w, 0, 1);

    wq.delete();
    put(SYNC); put(8'h00); put(8'h01); put(8'hAA);
    idle(TOUT - 1);
    check_val("to_early_err", 64'(err), 64'(0));
    idle(1);
    check_val("to_err", 64'(err), 64'(1));
    check_val("to_hold", 64'(cpu_hold), 64'(1));
    check_val("to_nwr", 64'(wq.size()), 64'(0));

    rand_words(3, w);
    load_frame(3, w, 0, 0);
    put(8'h00);
    check_val("junk_done_kept", 64'(done), 64'(1));
    put(SYNC);
    check_val("resync_done_clr", 64'(done), 64'(0));
    check_val("resync_hold", 64'(cpu_hold), 64'(1));
    check_val("resync_wc", 64'(word_count), 64'(0));
    rand_words(1, w);
    wq.delete();
    put(8'h00); put(8'h01);
    for (int b = 3; b >= 0; b--) put(w[0][8*b +: 8]);
    put(8'(w[0][31:24] + w[0][23:16] + w[0][15:8] + w[0][7:0]));
    idle(2);
    check_outputs(1, w, 1'b1, 1);

    wq.delete();
    put(SYNC); put(8'h00); put(8'h02); put(8'h11); put(8'h22); put(8'h33);
    reset = 1'b1;
    #1;
    check_val("mid_rst_we", 64'(imem_we), 64'(0));
    check_val("mid_rst_addr", 64'(imem_addr), 64'(0));
    check_val("mid_rst_wdata", 64'(imem_wdata), 64'(0));
    check_val("mid_rst_hold", 64'(cpu_hold), 64'(0));
    check_val("mid_rst_flags", 64'({done, err}), 64'(0));
    check_val("mid_rst_wc", 64'(word_count), 64'(0));
    idle(3);
    reset = 1'b0;
    idle(1);
    check_val("mid_rst_nwr", 64'(wq.size()), 64'(0));
    rand_words(2, w);
    load_frame(2, w, 0, 1);

    rand_words(MAXW, w);
    load_frame(MAXW, w, 0, 0);

    for (int t = 0; t < 14; t++) begin
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == SYNC) junk = 8'h00;
        put(junk);
      end
      n = $urandom_range(1, 8);
      rand_words(n, w);
      load_frame(n, w, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0,
                 $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
